// File: rtl/st_pkg.sv
// Shared stage-3/stage-4 definitions: funct codes, writer states, HI register.
package st_pkg;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b0001;
    localparam logic [3:0] FN_AND  = 4'b0010;
    localparam logic [3:0] FN_MULT = 4'b0100;
    localparam logic [3:0] FN_DIV  = 4'b0101;
    localparam logic [3:0] FN_OR   = 4'b0111;
    localparam logic [3:0] FN_SWAP = 4'b1000;
    localparam logic [3:0] FN_XOR  = 4'b1001;
    localparam logic [3:0] FN_CMP  = 4'b1010;
    localparam logic [3:0] FN_TST  = 4'b1011;
    localparam logic [3:0] FN_BR   = 4'b1100;
    localparam logic [3:0] FN_NOP  = 4'b1101;

    localparam logic [3:0] HI_REG_DEFAULT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR1  = 2'd1,
        ST_WR2  = 2'd2,
        ST_HALT = 2'd3
    } st_state_t;

    typedef enum logic [1:0] {
        WC_NONE   = 2'd0,
        WC_SINGLE = 2'd1,
        WC_DUAL   = 2'd2
    } wr_class_t;

    function automatic wr_class_t funct_class(input logic [3:0] f);
        wr_class_t c;
        case (f)
            FN_MULT, FN_DIV, FN_SWAP:                 c = WC_DUAL;
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR:    c = WC_SINGLE;
            default:                                  c = WC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/st4_result_writer.sv
// Stage-4 result writer: sequences one or two register-file writes per op
// and halts on add/sub overflow until software clears it.
module st4_result_writer
    import st_pkg::*;
#(
    parameter int         DATA_W = 16,
    parameter logic [3:0] HI_REG = HI_REG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_funct,
    input  logic [DATA_W-1:0] alu_out1,
    input  logic [DATA_W-1:0] alu_out2,
    input  logic              alu_exception,
    input  logic [3:0]        dest_reg,
    input  logic [3:0]        src_reg,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              exc_flag,
    output logic [3:0]        exc_funct,
    input  logic              exc_clear,
    output logic [7:0]        exc_count
);

    st_state_t         state;
    logic              dual_q;
    logic [3:0]        hi_addr;
    logic [DATA_W-1:0] hi_data;
    logic              accept;
    wr_class_t         cls;

    always_comb begin
        accept = in_valid && in_ready;
        cls    = funct_class(alu_funct);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            dual_q    <= 1'b0;
            hi_addr   <= '0;
            hi_data   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            exc_flag  <= 1'b0;
            exc_funct <= '0;
            exc_count <= '0;
        end else begin
            case (state)
                ST_HALT: begin
                    wr_en <= 1'b0;
                    if (exc_clear) begin
                        state    <= ST_IDLE;
                        exc_flag <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                ST_WR2: begin
                    state    <= ST_IDLE;
                    wr_en    <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    // WR1 of a dual op owns the next cycle; nothing was accepted.
                    if (state == ST_WR1 && dual_q) begin
                        state   <= ST_WR2;
                        dual_q  <= 1'b0;
                        wr_en   <= 1'b1;
                        wr_addr <= hi_addr;
                        wr_data <= hi_data;
                    end else if (accept && alu_exception) begin
                        state     <= ST_HALT;
                        wr_en     <= 1'b0;
                        in_ready  <= 1'b0;
                        exc_flag  <= 1'b1;
                        exc_funct <= alu_funct;
                        if (exc_count != 8'hFF)
                            exc_count <= exc_count + 8'd1;
                    end else if (accept && cls != WC_NONE) begin
                        state   <= ST_WR1;
                        wr_en   <= 1'b1;
                        wr_addr <= dest_reg;
                        wr_data <= alu_out1;
                        if (cls == WC_DUAL) begin
                            dual_q   <= 1'b1;
                            in_ready <= 1'b0;
                            hi_addr  <= (alu_funct == FN_SWAP) ? src_reg : HI_REG;
                            hi_data  <= alu_out2;
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        wr_en    <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_st4_result_writer.sv
// Scoreboard bench: driver queues expected writes, monitor pops on wr_en.
module tb_st4_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_funct;
    logic [15:0] alu_out1;
    logic [15:0] alu_out2;
    logic        alu_exception;
    logic [3:0]  dest_reg;
    logic [3:0]  src_reg;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        exc_flag;
    logic [3:0]  exc_funct;
    logic        exc_clear;
    logic [7:0]  exc_count;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q[$];

    st4_result_writer #(.DATA_W(16), .HI_REG(4'd15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_funct(alu_funct), .alu_out1(alu_out1), .alu_out2(alu_out2),
        .alu_exception(alu_exception),
        .dest_reg(dest_reg), .src_reg(src_reg),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .exc_flag(exc_flag), .exc_funct(exc_funct),
        .exc_clear(exc_clear), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none",
                         wr_addr, wr_data);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    failures++;
                    $display("FAIL write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                             wr_addr, wr_data, e[19:16], e[15:0]);
                end
            end
        end
    end

    // Present one op at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [3:0] f, input logic [15:0] o1,
                        input logic [15:0] o2, input logic ex,
                        input logic [3:0] d, input logic [3:0] s);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        in_valid      = 1'b1;
        alu_funct     = f;
        alu_out1      = o1;
        alu_out2      = o2;
        alu_exception = ex;
        dest_reg      = d;
        src_reg       = s;
        @(negedge clk);
        in_valid      = 1'b0;
        alu_exception = 1'b0;
    endtask

    task automatic clear_pulse();
        exc_clear = 1'b1;
        @(negedge clk);
        exc_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        alu_funct = '0;
        alu_out1 = '0;
        alu_out2 = '0;
        alu_exception = 1'b0;
        dest_reg = '0;
        src_reg = '0;
        exc_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_exc_flag", exc_flag, 0);
        chk("reset_exc_count", exc_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        // add -> r2 = 0x0007
        exp_q.push_back({4'd2, 16'h0007});
        send(4'b0000, 16'h0007, 16'h0000, 1'b0, 4'd2, 4'd0);
        chk("add_wr_en", wr_en, 1);
        chk("add_in_ready", in_ready, 1);
        @(negedge clk);
        chk("add_idle_wr_en", wr_en, 0);

        // mult: r3 then r15, ready low for two cycles
        exp_q.push_back({4'd3, 16'h5000});
        exp_q.push_back({4'd15, 16'h0001});
        send(4'b0100, 16'h5000, 16'h0001, 1'b0, 4'd3, 4'd9);
        chk("mult_rdy_c1", in_ready, 0);
        @(negedge clk);
        chk("mult_rdy_c2", in_ready, 0);
        chk("mult_wr_en_c2", wr_en, 1);
        @(negedge clk);
        chk("mult_rdy_c3", in_ready, 1);
        chk("mult_wr_en_c3", wr_en, 0);

        // swap: r4 = out1, r5 = out2
        exp_q.push_back({4'd4, 16'h1111});
        exp_q.push_back({4'd5, 16'h2222});
        send(4'b1000, 16'h1111, 16'h2222, 1'b0, 4'd4, 4'd5);
        @(negedge clk);
        @(negedge clk);

        // no-write op and unlisted code
        send(4'b1010, 16'hAAAA, 16'hBBBB, 1'b0, 4'd8, 4'd9);
        chk("nowrite_wr_en", wr_en, 0);
        chk("nowrite_in_ready", in_ready, 1);
        send(4'b0011, 16'hCCCC, 16'hDDDD, 1'b0, 4'd8, 4'd9);
        chk("unlisted_wr_en", wr_en, 0);

        // exc_clear outside HALT has no effect
        clear_pulse();
        chk("stray_clear_flag", exc_flag, 0);

        // overflowing add -> halt
        send(4'b0000, 16'h8000, 16'h0000, 1'b1, 4'd6, 4'd0);
        chk("exc_flag", exc_flag, 1);
        chk("exc_funct", exc_funct, 4'b0000);
        chk("exc_count", exc_count, 1);
        chk("exc_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("halt_held_rdy", in_ready, 0);
        chk("halt_wr_en", wr_en, 0);
        clear_pulse();
        chk("cleared_flag", exc_flag, 0);
        chk("cleared_rdy", in_ready, 1);
        chk("kept_count", exc_count, 1);

        // three back-to-back ORs, no bubble
        exp_q.push_back({4'd1, 16'h00F1});
        exp_q.push_back({4'd2, 16'h00F2});
        exp_q.push_back({4'd3, 16'h00F3});
        send(4'b0111, 16'h00F1, 16'h0, 1'b0, 4'd1, 4'd0);
        chk("or1_wr_en", wr_en, 1);
        chk("or1_rdy", in_ready, 1);
        send(4'b0111, 16'h00F2, 16'h0, 1'b0, 4'd2, 4'd0);
        chk("or2_wr_en", wr_en, 1);
        send(4'b0111, 16'h00F3, 16'h0, 1'b0, 4'd3, 4'd0);
        chk("or3_wr_en", wr_en, 1);
        @(negedge clk);

        // saturate the overflow counter with sub faults
        for (int i = 0; i < 256; i++) begin
            send(4'b0001, 16'h7FFF, 16'h0, 1'b1, 4'd7, 4'd0);
            clear_pulse();
        end
        chk("sat_count", exc_count, 8'hFF);
        chk("sat_funct", exc_funct, 4'b0001);

        // reset during WR1 of div drops the remainder write
        exp_q.push_back({4'd7, 16'h0042});
        send(4'b0101, 16'h0042, 16'h0003, 1'b0, 4'd7, 4'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_exc_flag", exc_flag, 0);
        chk("rst_exc_funct", exc_funct, 0);
        chk("rst_exc_count", exc_count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_wr2", wr_en, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
